// File: rtl/counter_ctrl.sv
// counter_ctrl
//   Sequencing controller that wraps an up-counter into a programmable timer with
//   start/stop/pause control, a latched terminal count and one-shot or periodic
//   operation. The controller owns the count register.
//
//   Ports
//     clk       in   1      clock, all logic on posedge
//     reset_n   in   1      synchronous active-low reset
//     start     in   1      (re)load tc, clear count, enter RUN
//     stop      in   1      abort: clear count, enter IDLE (beats start)
//     pause     in   1      freeze count while high (RUN <-> HOLD)
//     periodic  in   1      sampled with start: 1 = auto-reload, 0 = one-shot
//     tc        in   WIDTH  terminal count, latched on accepted start
//     count     out  WIDTH  current count
//     busy      out  1      high in RUN or HOLD
//     done      out  1      registered one-cycle pulse when the terminal count is consumed
//     state     out  2      IDLE=00 RUN=01 HOLD=10 DONE=11
//
//   Optional feature macro: COUNTER_CTRL_PRESCALE_EN
//     When defined, the count advances only every PRESCALE clocks spent in RUN.
//     When undefined, the count advances every RUN clock and PRESCALE is ignored.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | stopped, count held at 0
//   RUN   | counting toward tc_q
//   HOLD  | paused, count (and prescaler phase) frozen
//   DONE  | one-shot finished, count holds tc_q until start or stop

module counter_ctrl #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             periodic,
    input  logic [WIDTH-1:0] tc,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   tc_q, tc_d;
    logic               mode_q, mode_d;
    logic               done_q, done_d;
    logic               tick;

`ifdef COUNTER_CTRL_PRESCALE_EN
    localparam int PS_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]    ps_q, ps_d;

    assign tick = (ps_q == PS_MAX);
`else
    logic               unused_prescale;

    assign unused_prescale = (PRESCALE >= 2);
    assign tick = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = tc_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
`ifdef COUNTER_CTRL_PRESCALE_EN
        ps_d    = ps_q;
`endif

        if (stop) begin
            state_d = ST_IDLE;
            count_d = '0;
`ifdef COUNTER_CTRL_PRESCALE_EN
            ps_d    = '0;
`endif
        end else if (start) begin
            state_d = ST_RUN;
            count_d = '0;
            tc_d    = tc;
            mode_d  = periodic;
`ifdef COUNTER_CTRL_PRESCALE_EN
            ps_d    = '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    count_d = '0;
                end
                ST_RUN: begin
                    if (pause) begin
                        // Pause wins over a pending terminal count: no done here.
                        state_d = ST_HOLD;
                    end else begin
`ifdef COUNTER_CTRL_PRESCALE_EN
                        ps_d = tick ? '0 : ps_q + 1'b1;
`endif
                        if (tick) begin
                            if (count_q == tc_q) begin
                                done_d = 1'b1;
                                if (mode_q) begin
                                    count_d = '0;
                                end else begin
                                    state_d = ST_DONE;
                                end
                            end else begin
                                count_d = count_q + 1'b1;
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    // Resume edge only changes state; counting restarts next edge.
                    if (!pause) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            tc_q    <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef COUNTER_CTRL_PRESCALE_EN
            ps_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
`ifdef COUNTER_CTRL_PRESCALE_EN
            ps_q    <= ps_d;
`endif
        end
    end

    assign count = count_q;
    assign done  = done_q;
    assign state = state_q;
    assign busy  = (state_q == ST_RUN) || (state_q == ST_HOLD);

endmodule
